// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the display scheduler.
//               DISPLAY_SCHED_GAP_EN adds the blank GAP state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int DISP_VALUE_W = 16;
    localparam logic [DISP_VALUE_W-1:0] DISP_BLANK_VALUE = 16'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_ALERT = 2'd2
`ifdef DISPLAY_SCHED_GAP_EN
        ,
        S_GAP   = 2'd3
`endif
    } disp_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over sources 1..NUM_SRC-1,
//               searching from i_ptr+1 and wrapping; source 0 never picked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_pick,
    output logic               o_found
);

    // Rotating sources occupy slots 1..NUM_SRC-1; the owner itself is checked last.
    always_comb begin
        int idx;
        idx     = 0;
        o_pick  = '0;
        o_found = 1'b0;
        for (int k = 1; k < NUM_SRC; k++) begin
            idx = ((int'(i_ptr) + k - 1) % (NUM_SRC - 1)) + 1;
            if (!o_found && i_req[idx]) begin
                o_pick[idx] = 1'b1;
                o_found     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scheduler.sv
// ============================================================================
// Module      : display_scheduler
// Description : Time-shares the 7-segment display between requesters with
//               round-robin dwell and alert preemption (source 0).
//               Macro DISPLAY_SCHED_GAP_EN inserts blank gaps between sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC          = 4,
    parameter int DWELL_CYCLES     = 200_000_000,
    parameter int ALERT_MIN_CYCLES = 100_000_000,
    parameter int GAP_CYCLES       = 10_000_000
) (
    input  logic                            clock_100Mhz,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              src_req,
    input  logic [DISP_VALUE_W*NUM_SRC-1:0] src_value,
    output logic [DISP_VALUE_W-1:0]         displayed_number,
    output logic                            display_blank,
    output logic [NUM_SRC-1:0]              grant,
    output logic                            switch_pulse
);

    localparam int c_max_da     = (DWELL_CYCLES > ALERT_MIN_CYCLES) ? DWELL_CYCLES : ALERT_MIN_CYCLES;
    localparam int c_max_cycles = (c_max_da > GAP_CYCLES) ? c_max_da : GAP_CYCLES;
    localparam int CNT_W        = $clog2(c_max_cycles) + 1;
    localparam int PTR_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_dwell_load = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_alert_load = CNT_W'(ALERT_MIN_CYCLES - 1);
`ifdef DISPLAY_SCHED_GAP_EN
    localparam logic [CNT_W-1:0]   c_gap_load   = CNT_W'(GAP_CYCLES - 1);
`endif
    localparam logic [NUM_SRC-1:0] c_alert_gnt  = NUM_SRC'(1);

    disp_sched_state_t       r_state, w_state_nxt;
    logic [NUM_SRC-1:0]      r_grant, w_grant_nxt;
    logic [DISP_VALUE_W-1:0] r_number, w_number_nxt;
    logic                    r_blank;
    logic                    r_pulse, w_pulse_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]        r_ptr, w_ptr_nxt;

    logic [NUM_SRC-1:0]      w_pick;
    logic                    w_found;
    logic [PTR_W-1:0]        w_pick_idx;
    logic                    w_owner_req;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (src_req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_pick_idx = r_ptr;
        for (int i = 1; i < NUM_SRC; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_owner_req = |(src_req & r_grant);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_pulse_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (src_req[0]) begin
                    w_state_nxt = S_ALERT;
                    w_grant_nxt = c_alert_gnt;
                    w_cnt_nxt   = c_alert_load;
                    w_pulse_nxt = 1'b1;
                end else if (w_found) begin
                    w_state_nxt = S_SHOW;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = c_dwell_load;
                    w_ptr_nxt   = w_pick_idx;
                    w_pulse_nxt = 1'b1;
                end
            end

            S_SHOW: begin
                if (src_req[0]) begin
                    w_state_nxt = S_ALERT;
                    w_grant_nxt = c_alert_gnt;
                    w_cnt_nxt   = c_alert_load;
                    w_pulse_nxt = 1'b1;
                end else if (!w_owner_req || (r_cnt == '0)) begin
                    if (!w_found) begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                    end else if (w_pick == r_grant) begin
                        // Sole requester: re-arm the dwell without a visible switch.
                        w_cnt_nxt = c_dwell_load;
                    end else begin
`ifdef DISPLAY_SCHED_GAP_EN
                        w_state_nxt = S_GAP;
                        w_grant_nxt = '0;
                        w_cnt_nxt   = c_gap_load;
`else
                        w_state_nxt = S_SHOW;
                        w_grant_nxt = w_pick;
                        w_cnt_nxt   = c_dwell_load;
                        w_ptr_nxt   = w_pick_idx;
                        w_pulse_nxt = 1'b1;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end

            S_ALERT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (!src_req[0]) begin
                    if (w_found) begin
                        w_state_nxt = S_SHOW;
                        w_grant_nxt = w_pick;
                        w_cnt_nxt   = c_dwell_load;
                        w_ptr_nxt   = w_pick_idx;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end

`ifdef DISPLAY_SCHED_GAP_EN
            S_GAP: begin
                w_grant_nxt = '0;
                if (src_req[0]) begin
                    w_state_nxt = S_ALERT;
                    w_grant_nxt = c_alert_gnt;
                    w_cnt_nxt   = c_alert_load;
                    w_pulse_nxt = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (w_found) begin
                    w_state_nxt = S_SHOW;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = c_dwell_load;
                    w_ptr_nxt   = w_pick_idx;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Value is selected from the next grant so source edits show one edge later.
    always_comb begin
        w_number_nxt = DISP_BLANK_VALUE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant_nxt[i]) begin
                w_number_nxt = src_value[DISP_VALUE_W*i +: DISP_VALUE_W];
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_number <= DISP_BLANK_VALUE;
            r_blank  <= 1'b1;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= PTR_W'(NUM_SRC - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_number <= w_number_nxt;
            r_blank  <= (w_grant_nxt == '0);
            r_pulse  <= w_pulse_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign displayed_number = r_number;
    assign display_blank    = r_blank;
    assign grant            = r_grant;
    assign switch_pulse     = r_pulse;

endmodule

`default_nettype wire
